// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754 single-precision multiplier, one multiplier bit per clock, 26-cycle latency.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mul_seq #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] data_iA,
    input  logic [DATAWIDTH-1:0] data_iB,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        NORM  = 2'd2,
        ROUND = 2'd3
    } state_t;

    state_t      state;
    logic [23:0] a_reg;
    logic [23:0] b_reg;
    logic [47:0] acc;
    logic [4:0]  cnt;
    logic        sign_q;
    logic [9:0]  exp_q;
    logic [22:0] mant_q;
    logic        special_q;
    logic [31:0] special_val_q;
`ifdef FP_MUL_RNE_EN
    logic        guard_q;
    logic        sticky_q;
`endif

    // Operand classification; exponent field 0 flushes denormals to zero.
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        sign_c;
    logic        zero_a;
    logic        zero_b;
    logic        inf_a;
    logic        inf_b;
    logic        nan_a;
    logic        nan_b;
    logic        special_c;
    logic [31:0] special_val_c;
    logic [9:0]  exp_sum_c;

    assign exp_a     = data_iA[30:23];
    assign exp_b     = data_iB[30:23];
    assign sign_c    = data_iA[31] ^ data_iB[31];
    assign zero_a    = (exp_a == 8'd0);
    assign zero_b    = (exp_b == 8'd0);
    assign inf_a     = (exp_a == 8'hFF) && (data_iA[22:0] == 23'd0);
    assign inf_b     = (exp_b == 8'hFF) && (data_iB[22:0] == 23'd0);
    assign nan_a     = (exp_a == 8'hFF) && (data_iA[22:0] != 23'd0);
    assign nan_b     = (exp_b == 8'hFF) && (data_iB[22:0] != 23'd0);
    assign exp_sum_c = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;

    always_comb begin
        special_c     = 1'b1;
        special_val_c = 32'h7FC0_0000;
        if (nan_a || nan_b) begin
            special_val_c = 32'h7FC0_0000;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            special_val_c = 32'h7FC0_0000;
        end else if (inf_a || inf_b) begin
            special_val_c = {sign_c, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            special_val_c = {sign_c, 31'd0};
        end else begin
            special_c     = 1'b0;
            special_val_c = 32'd0;
        end
    end

    // Shift-add step: add multiplicand into the upper half, keep the carry.
    logic [24:0] sum_c;
    assign sum_c = {1'b0, acc[47:24]} + (b_reg[0] ? {1'b0, a_reg} : 25'd0);

    logic [22:0] mant_rnd;
    logic [9:0]  exp_rnd;
    logic [31:0] result_c;

`ifdef FP_MUL_RNE_EN
    logic        round_inc;
    logic        mant_carry;
    assign round_inc = guard_q & (sticky_q | mant_q[0]);
    always_comb begin
        {mant_carry, mant_rnd} = {1'b0, mant_q} + {23'd0, round_inc};
        exp_rnd                = exp_q + {9'd0, mant_carry};
    end
`else
    always_comb begin
        mant_rnd = mant_q;
        exp_rnd  = exp_q;
    end
`endif

    always_comb begin
        result_c = {sign_c, 31'd0};
        if (special_q) begin
            result_c = special_val_q;
        end else if ($signed(exp_rnd) >= 10'sd255) begin
            result_c = {sign_q, 8'hFF, 23'd0};
        end else if ($signed(exp_rnd) <= 10'sd0) begin
            result_c = {sign_q, 31'd0};
        end else begin
            result_c = {sign_q, exp_rnd[7:0], mant_rnd};
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_o        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
`ifdef FP_MUL_RNE_EN
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg         <= {1'b1, data_iA[22:0]};
                        b_reg         <= {1'b1, data_iB[22:0]};
                        sign_q        <= sign_c;
                        exp_q         <= exp_sum_c;
                        acc           <= '0;
                        cnt           <= '0;
                        special_q     <= special_c;
                        special_val_q <= special_val_c;
                        busy          <= 1'b1;
                        state         <= MUL;
                    end
                end
                MUL: begin
                    acc   <= 48'({sum_c, acc[23:0]} >> 1);
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd23) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (acc[47]) begin
                        exp_q    <= exp_q + 10'd1;
                        mant_q   <= acc[46:24];
`ifdef FP_MUL_RNE_EN
                        guard_q  <= acc[23];
                        sticky_q <= |acc[22:0];
`endif
                    end else begin
                        mant_q   <= acc[45:23];
`ifdef FP_MUL_RNE_EN
                        guard_q  <= acc[22];
                        sticky_q <= |acc[21:0];
`endif
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    data_o <= result_c;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking bench for fp_mul_seq: vector table, scoreboard, handshake and reset corners.
module tb_fp_mul_seq;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data_iA = '0;
    logic [31:0] data_iB = '0;
    logic        busy;
    logic        done;
    logic [31:0] data_o;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [31:0] sb[$];
    string       cur_name = "none";

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        string       name;
    } vec_t;

    vec_t vecs[11];

    always #5 Clk = ~Clk;

    fp_mul_seq #(.DATAWIDTH(32)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .start  (start),
        .data_iA(data_iA),
        .data_iB(data_iB),
        .busy   (busy),
        .done   (done),
        .data_o (data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pushed expectation.
    always @(negedge Clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got %h expected no done", data_o);
            end else begin
                check({"result ", cur_name}, data_o, sb.pop_front());
            end
        end
    end

    task automatic wait_done(input string name);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge Clk);
            lat++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout %s: got no done after %0d cycles expected done", name, lat);
        end else begin
            check({"latency ", name}, 32'(lat), 32'd26);
            check({"busy_cycles ", name}, 32'(busy_cycles), 32'd26);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y, input string name);
        @(negedge Clk);
        data_iA  = a;
        data_iB  = b;
        start    = 1'b1;
        cur_name = name;
        sb.push_back(y);
        @(negedge Clk);
        start   = 1'b0;
        data_iA = $urandom;
        data_iB = $urandom;
        wait_done(name);
        @(negedge Clk);
    endtask

    initial begin
        int base;
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, "1.5x2"};
        vecs[1]  = '{32'h40000000, 32'h40400000, 32'h40C00000, "2x3"};
`ifdef FP_MUL_RNE_EN
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie"};
`else
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, "tie"};
`endif
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow"};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, "underflow"};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero"};
        vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan"};
        vecs[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, "negzero"};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, "denormal"};
        vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, "neginf_x_2"};
        vecs[10] = '{32'h3FC00000, 32'hC0000000, 32'hC0400000, "1.5xneg2"};

        repeat (3) @(negedge Clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset data_o", data_o, 32'd0);
        nReset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].name);
        end

        // Back-to-back with start held high: second op captured in the done cycle.
        @(negedge Clk);
        data_iA  = 32'hC0400000;
        data_iB  = 32'h3F000000;
        start    = 1'b1;
        cur_name = "b2b_first";
        sb.push_back(32'hBFC00000);
        @(negedge Clk);
        wait_done("b2b_first");
        data_iA = 32'h3FC00000;
        data_iB = 32'h3FC00000;
        sb.push_back(32'h40100000);
        @(negedge Clk);
        start    = 1'b0;
        cur_name = "b2b_second";
        wait_done("b2b_second");
        @(negedge Clk);

        // start pulsed while busy must be ignored.
        @(negedge Clk);
        data_iA  = 32'h40000000;
        data_iB  = 32'h40400000;
        start    = 1'b1;
        cur_name = "busy_ignore";
        sb.push_back(32'h40C00000);
        base = done_cnt;
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        data_iA = 32'h7F800000;
        data_iB = 32'h3F800000;
        start   = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (60) @(negedge Clk);
        check("busy_ignore done_count", 32'(done_cnt - base), 32'd1);
        check("busy_ignore data_o", data_o, 32'h40C00000);

        // Reset mid-operation aborts immediately.
        @(negedge Clk);
        data_iA  = 32'h3FC00000;
        data_iB  = 32'h40000000;
        start    = 1'b1;
        cur_name = "abort";
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        nReset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort data_o", data_o, 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        base = done_cnt;
        repeat (40) @(negedge Clk);
        check("abort no_done", 32'(done_cnt - base), 32'd0);

        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, "after_reset");
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
